// File: rtl/cam_pkg.sv
// Shared camera-pipeline constants, FSM state encoding and pixel type.
package cam_pkg;

    localparam int unsigned PIX_W       = 12;
    localparam int unsigned IMG_W       = 640;
    localparam int unsigned IMG_H       = 480;
    localparam int unsigned LINE_LEN    = 680;
    localparam int unsigned FLUSH_LINES = 2;
    localparam int unsigned ADDR_W      = 19;
    localparam int unsigned WIN_LAT     = 2;
    localparam int unsigned X_W         = 10;
    localparam int unsigned Y_W         = 9;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        BLANK,
        DRAIN
    } fsm_state_t;

    typedef logic [PIX_W-1:0] pixel_t;

endpackage

// File: rtl/tag_delay.sv
// Generic N-stage register pipeline with synchronous reset.
module tag_delay #(
    parameter int unsigned W = 1,
    parameter int unsigned N = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (N == 0) begin : g_pass
            assign q = d;
        end else begin : g_pipe
            logic [W-1:0] r_pipe [N];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int unsigned i = 0; i < N; i++) r_pipe[i] <= '0;
                end else begin
                    r_pipe[0] <= d;
                    for (int unsigned i = 1; i < N; i++) r_pipe[i] <= r_pipe[i-1];
                end
            end

            assign q = r_pipe[N-1];
        end
    endgenerate

endmodule

// File: rtl/pixel_buf_feeder.sv
// Raster-scan feeder for the 3x3 line-window buffer: reads the frame buffer,
// pads blank/flush beats with zeros and emits a latency-matched coordinate tag.
module pixel_buf_feeder #(
    parameter int unsigned IMG_W       = cam_pkg::IMG_W,
    parameter int unsigned IMG_H       = cam_pkg::IMG_H,
    parameter int unsigned LINE_LEN    = cam_pkg::LINE_LEN,
    parameter int unsigned FLUSH_LINES = cam_pkg::FLUSH_LINES,
    parameter int unsigned ADDR_W      = cam_pkg::ADDR_W,
    parameter int unsigned PIX_W       = cam_pkg::PIX_W,
    parameter int unsigned WIN_LAT     = cam_pkg::WIN_LAT
) (
    input  logic              readClk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              frameDone,
    output logic [ADDR_W-1:0] fbAddr,
    input  logic [PIX_W-1:0]  fbData,
    output logic [9:0]        outX,
    output logic [1:0]        outY,
    output logic [PIX_W-1:0]  pixelOut,
    output logic              pixelValid,
    output logic [9:0]        tagX,
    output logic [8:0]        tagY,
    output logic              tagValid
);

    localparam int unsigned X_W       = cam_pkg::X_W;
    localparam int unsigned Y_W       = cam_pkg::Y_W;
    localparam int unsigned DRN_W     = $clog2(WIN_LAT + 1) + 1;
    localparam int unsigned TAG_W     = 1 + X_W + Y_W;
    localparam logic [X_W-1:0]   LAST_X     = X_W'(LINE_LEN - 1);
    localparam logic [X_W-1:0]   IMG_W_X    = X_W'(IMG_W);
    localparam logic [Y_W-1:0]   IMG_H_Y    = Y_W'(IMG_H);
    localparam logic [Y_W-1:0]   LAST_LINE  = Y_W'(IMG_H + FLUSH_LINES - 1);
    localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(WIN_LAT);

    cam_pkg::fsm_state_t r_state, w_state_n;
    logic [X_W-1:0]    r_x, w_x_n;
    logic [Y_W-1:0]    r_line, w_line_n;
    logic [ADDR_W-1:0] r_addr, w_addr_n;
    logic [DRN_W-1:0]  r_drain, w_drain_n;
    logic              r_busy, w_busy_n;
    logic              r_done, w_done_n;

    logic [X_W-1:0]    r_out_x;
    logic [1:0]        r_out_y;
    logic [Y_W-1:0]    r_line1;
    logic              r_pix_valid;
    logic              r_beat;
    logic [TAG_W-1:0]  w_tag_q;

    // Stage 0: scan counters and FSM state
    always_ff @(posedge readClk) begin
        if (reset) begin
            r_state <= cam_pkg::IDLE;
            r_x     <= '0;
            r_line  <= '0;
            r_addr  <= '0;
            r_drain <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_x     <= w_x_n;
            r_line  <= w_line_n;
            r_addr  <= w_addr_n;
            r_drain <= w_drain_n;
            r_busy  <= w_busy_n;
            r_done  <= w_done_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_x_n     = r_x;
        w_line_n  = r_line;
        w_addr_n  = r_addr;
        w_drain_n = r_drain;
        w_done_n  = 1'b0;
        case (r_state)
            cam_pkg::IDLE: begin
                if (start && !r_busy) begin
                    w_state_n = cam_pkg::ACTIVE;
                    w_x_n     = '0;
                    w_line_n  = '0;
                    w_addr_n  = '0;
                end
            end
            cam_pkg::ACTIVE, cam_pkg::BLANK: begin
                if (r_x == LAST_X) begin
                    w_x_n = '0;
                    if (r_line == LAST_LINE) begin
                        w_state_n = cam_pkg::DRAIN;
                        w_line_n  = '0;
                        w_drain_n = '0;
                    end else begin
                        w_line_n  = r_line + Y_W'(1);
                        w_state_n = (w_line_n < IMG_H_Y) ? cam_pkg::ACTIVE : cam_pkg::BLANK;
                    end
                end else begin
                    w_x_n     = r_x + X_W'(1);
                    w_state_n = (r_line < IMG_H_Y && w_x_n < IMG_W_X) ? cam_pkg::ACTIVE
                                                                      : cam_pkg::BLANK;
                end
                // Advance only when another read follows, so the last read address is held
                if (w_state_n == cam_pkg::ACTIVE) w_addr_n = r_addr + ADDR_W'(1);
            end
            cam_pkg::DRAIN: begin
                if (r_drain == DRAIN_LAST) begin
                    w_state_n = cam_pkg::IDLE;
                    w_done_n  = 1'b1;
                end else begin
                    w_drain_n = r_drain + DRN_W'(1);
                end
            end
            default: w_state_n = cam_pkg::IDLE;
        endcase
        w_busy_n = (w_state_n != cam_pkg::IDLE) || w_done_n;
    end

    // Stage 1: registered copy of stage 0, aligned with returning read data
    always_ff @(posedge readClk) begin
        if (reset) begin
            r_out_x     <= '0;
            r_out_y     <= '0;
            r_line1     <= '0;
            r_pix_valid <= 1'b0;
            r_beat      <= 1'b0;
        end else begin
            r_out_x     <= r_x;
            r_out_y     <= r_line[1:0];
            r_line1     <= r_line;
            r_pix_valid <= (r_state == cam_pkg::ACTIVE);
            r_beat      <= (r_state == cam_pkg::ACTIVE) || (r_state == cam_pkg::BLANK);
        end
    end

    tag_delay #(
        .W (TAG_W),
        .N (WIN_LAT)
    ) u_tag_delay (
        .clk   (readClk),
        .reset (reset),
        .d     ({r_beat, r_out_x, r_line1}),
        .q     (w_tag_q)
    );

    assign busy       = r_busy;
    assign frameDone  = r_done;
    assign fbAddr     = r_addr;
    assign outX       = r_out_x;
    assign outY       = r_out_y;
    assign pixelValid = r_pix_valid;
    assign pixelOut   = r_pix_valid ? fbData : '0;
    assign tagValid   = w_tag_q[TAG_W-1];
    assign tagX       = w_tag_q[TAG_W-2 -: X_W];
    assign tagY       = w_tag_q[Y_W-1:0];

endmodule
